// File: rtl/lsu_lockstep_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lsu_lockstep_ctrl_pkg
//   Shared definitions for the LSU lockstep controller: the FSM state
//   encoding, the default parameter values and a small decode helper.
//
//   States are 2 bits wide. 2'b11 is never entered, but if it ever shows
//   up (for example after an upset) it behaves exactly like ERROR.
// -----------------------------------------------------------------------------
package lsu_lockstep_ctrl_pkg;

    typedef enum logic [1:0] {
        LKSTP_EMPTY = 2'b00,
        LKSTP_FULL  = 2'b01,
        LKSTP_ERROR = 2'b10
    } lkstp_state_e;

    localparam int LKSTP_SIGW_DFLT    = 32;
    localparam int LKSTP_TIMEOUT_DFLT = 64;
    localparam int LKSTP_CNTW_DFLT    = 8;

    // True for ERROR and for the unused 2'b11 code, which is folded onto ERROR.
    function automatic logic lkstp_is_error(input logic [1:0] st);
        return st[1];
    endfunction

endpackage

// File: rtl/lsu_lockstep_ctrl_dfflr.sv
// -----------------------------------------------------------------------------
// lsu_lockstep_ctrl_dfflr
//   Generic load-enabled flop bank with an asynchronous active-low reset
//   to zero. All datapath state in the lockstep controller is built from it.
//
// Ports
//   clk    in   1    clock
//   rst_n  in   1    async active-low reset, clears qout to 0
//   lden   in   1    load enable
//   dnxt   in   DW   next value, captured when lden=1
//   qout   out  DW   registered value
// -----------------------------------------------------------------------------
module lsu_lockstep_ctrl_dfflr #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    // Hold the value unless loaded; reset drops straight to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qout <= '0;
        end else if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/lsu_lockstep_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_lockstep_ctrl
//   Sequences the redundant-core LSU result buffer. Each main-core LSU event
//   is held (by its signature) until the redundant core replays and consumes
//   it; the two signatures are then compared. A mismatch, or the redundant
//   core failing to consume within TIMEOUT cycles, raises a sticky error
//   that only clr_err removes.
//
// Parameters
//   SIGW     width of the event signature
//   TIMEOUT  cycles allowed in FULL before the redundant core must consume
//   CNTW     width of the timeout counter and of mis_cnt; 2**CNTW > TIMEOUT
//
// Ports
//   clk          in   1     core clock
//   rst_n        in   1     async active-low reset
//   main_evt     in   1     main-core LSU event handshake this cycle
//   main_sig     in   SIGW  signature of the main-core event
//   main_stall   out  1     backpressure to main-core LSU issue
//   buf_lden     out  1     load enable to the LSU result buffer
//   red_evt      in   1     redundant core consumed the buffered event
//   red_sig      in   SIGW  signature of the redundant-core event
//   clr_err      in   1     pulse: leave ERROR
//   lkstp_err    out  1     sticky error (mismatch or timeout)
//   err_timeout  out  1     cause while lkstp_err=1: 1 timeout, 0 mismatch
//   mis_cnt      out  CNTW  saturating count of error entries
//
// Configuration
//   E203_LOCKSTEP_MISMATCH_CNT_EN
//     defined:   mis_cnt counts every entry into ERROR, saturating at all-ones.
//     undefined: mis_cnt is tied to zero and no counter flops exist.
// -----------------------------------------------------------------------------
module lsu_lockstep_ctrl
    import lsu_lockstep_ctrl_pkg::*;
#(
    parameter int SIGW    = LKSTP_SIGW_DFLT,
    parameter int TIMEOUT = LKSTP_TIMEOUT_DFLT,
    parameter int CNTW    = LKSTP_CNTW_DFLT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            main_evt,
    input  logic [SIGW-1:0] main_sig,
    output logic            main_stall,
    output logic            buf_lden,
    input  logic            red_evt,
    input  logic [SIGW-1:0] red_sig,
    input  logic            clr_err,
    output logic            lkstp_err,
    output logic            err_timeout,
    output logic [CNTW-1:0] mis_cnt
);

    lkstp_state_e    state_q;
    lkstp_state_e    state_d;

    logic [SIGW-1:0] sig_q;
    logic            sig_ld;

    logic [CNTW-1:0] tmo_q;
    logic [CNTW-1:0] tmo_nxt;
    logic            tmo_ld;

    logic            err_set;
    logic            err_cause_tmo;
    logic            err_clr;

    logic            sig_match;
    logic            tmo_at_limit;

    // The stored signature is only meaningful against red_sig while red_evt
    // is high; every use below is qualified by red_evt.
    assign sig_match    = (sig_q == red_sig);
    assign tmo_at_limit = (tmo_q == CNTW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LKSTP_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the load strobes for the signature, the timeout
    // counter and the error flags. A matching consume coinciding with a new
    // main event refills the slot in the same cycle so the pipeline sees no
    // bubble. Anything that is not EMPTY or FULL is treated as ERROR.
    always_comb begin
        state_d       = state_q;
        sig_ld        = 1'b0;
        tmo_ld        = 1'b0;
        tmo_nxt       = '0;
        err_set       = 1'b0;
        err_cause_tmo = 1'b0;
        err_clr       = 1'b0;

        case (state_q)
            LKSTP_EMPTY: begin
                if (main_evt) begin
                    sig_ld  = 1'b1;
                    tmo_ld  = 1'b1;
                    state_d = LKSTP_FULL;
                end
            end

            LKSTP_FULL: begin
                if (red_evt) begin
                    if (sig_match) begin
                        if (main_evt) begin
                            sig_ld = 1'b1;
                            tmo_ld = 1'b1;
                        end else begin
                            state_d = LKSTP_EMPTY;
                        end
                    end else begin
                        state_d = LKSTP_ERROR;
                        err_set = 1'b1;
                    end
                end else if (tmo_at_limit) begin
                    state_d       = LKSTP_ERROR;
                    err_set       = 1'b1;
                    err_cause_tmo = 1'b1;
                end else begin
                    tmo_ld  = 1'b1;
                    tmo_nxt = tmo_q + CNTW'(1);
                end
            end

            default: begin
                if (clr_err) begin
                    state_d = LKSTP_EMPTY;
                    err_clr = 1'b1;
                end
            end
        endcase
    end

    // Outputs to the main core and the result buffer. In FULL the main core
    // may only advance in a cycle where the slot is being consumed, and a
    // main_evt it raises anyway is ignored (no lden, no capture).
    always_comb begin
        main_stall = 1'b1;
        buf_lden   = 1'b0;

        if (lkstp_is_error(state_q)) begin
            main_stall = 1'b1;
            buf_lden   = 1'b0;
        end else if (state_q == LKSTP_FULL) begin
            main_stall = ~red_evt;
            buf_lden   = red_evt & sig_match & main_evt;
        end else begin
            main_stall = 1'b0;
            buf_lden   = main_evt;
        end
    end

    // Signature of the event currently held for the redundant core.
    lsu_lockstep_ctrl_dfflr #(.DW(SIGW)) u_sig_dff (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (sig_ld),
        .dnxt  (main_sig),
        .qout  (sig_q)
    );

    // Cycles spent in FULL without consumption; restarted on every capture.
    lsu_lockstep_ctrl_dfflr #(.DW(CNTW)) u_tmo_dff (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (tmo_ld),
        .dnxt  (tmo_nxt),
        .qout  (tmo_q)
    );

    // Sticky error flag and its cause; both set on entry to ERROR and
    // cleared only when clr_err takes the FSM out of ERROR.
    lsu_lockstep_ctrl_dfflr #(.DW(1)) u_err_dff (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (err_set | err_clr),
        .dnxt  (err_set),
        .qout  (lkstp_err)
    );

    lsu_lockstep_ctrl_dfflr #(.DW(1)) u_err_tmo_dff (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (err_set | err_clr),
        .dnxt  (err_set & err_cause_tmo),
        .qout  (err_timeout)
    );

`ifdef E203_LOCKSTEP_MISMATCH_CNT_EN
    logic [CNTW-1:0] cnt_q;

    // Error-entry counter; it stops at all-ones and survives clr_err.
    lsu_lockstep_ctrl_dfflr #(.DW(CNTW)) u_cnt_dff (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (err_set & ~(&cnt_q)),
        .dnxt  (cnt_q + CNTW'(1)),
        .qout  (cnt_q)
    );

    assign mis_cnt = cnt_q;
`else
    assign mis_cnt = '0;
`endif

endmodule

// File: tb/tb_lsu_lockstep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_lockstep_ctrl
//   Self-checking bench for lsu_lockstep_ctrl with default parameters.
//   A behavioural model predicts every cycle's outputs; predictions are
//   queued when a cycle is driven and compared when the DUT's outputs for
//   that cycle have settled.
// -----------------------------------------------------------------------------
module tb_lsu_lockstep_ctrl;

    localparam int SIGW    = 32;
    localparam int TIMEOUT = 64;
    localparam int CNTW    = 8;

    logic            clk;
    logic            rst_n;
    logic            main_evt;
    logic [SIGW-1:0] main_sig;
    logic            main_stall;
    logic            buf_lden;
    logic            red_evt;
    logic [SIGW-1:0] red_sig;
    logic            clr_err;
    logic            lkstp_err;
    logic            err_timeout;
    logic [CNTW-1:0] mis_cnt;

    typedef struct packed {
        logic            lden;
        logic            stall;
        logic            err;
        logic            etmo;
        logic [CNTW-1:0] cnt;
    } exp_t;

    exp_t scoreboard[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: 0 EMPTY, 1 FULL, 2 ERROR.
    int              m_state;
    logic [SIGW-1:0] m_sig;
    int              m_tmo;
    logic            m_err;
    logic            m_etmo;
    logic [CNTW-1:0] m_cnt;

    lsu_lockstep_ctrl #(
        .SIGW    (SIGW),
        .TIMEOUT (TIMEOUT),
        .CNTW    (CNTW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .main_evt    (main_evt),
        .main_sig    (main_sig),
        .main_stall  (main_stall),
        .buf_lden    (buf_lden),
        .red_evt     (red_evt),
        .red_sig     (red_sig),
        .clr_err     (clr_err),
        .lkstp_err   (lkstp_err),
        .err_timeout (err_timeout),
        .mis_cnt     (mis_cnt)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelEnterError(input logic cause_tmo);
        m_state = 2;
        m_err   = 1'b1;
        m_etmo  = cause_tmo;
`ifdef E203_LOCKSTEP_MISMATCH_CNT_EN
        if (m_cnt != {CNTW{1'b1}}) m_cnt = m_cnt + 1'b1;
`endif
    endtask

    // Drives one cycle (called at a falling edge), predicts the outcome,
    // then checks the combinational outputs of that cycle and the registered
    // outputs just after the following rising edge.
    task automatic applyStimulus(input string tag, input logic m, input logic [SIGW-1:0] ms,
                                 input logic r, input logic [SIGW-1:0] rs, input logic c);
        exp_t e;
        exp_t got;
        main_evt = m;
        main_sig = ms;
        red_evt  = r;
        red_sig  = rs;
        clr_err  = c;

        case (m_state)
            0: begin e.lden = m; e.stall = 1'b0; end
            1: begin e.lden = r && (rs == m_sig) && m; e.stall = !r; end
            default: begin e.lden = 1'b0; e.stall = 1'b1; end
        endcase

        case (m_state)
            0: if (m) begin m_sig = ms; m_tmo = 0; m_state = 1; end
            1: begin
                if (r) begin
                    if (rs == m_sig) begin
                        if (m) begin m_sig = ms; m_tmo = 0; end
                        else m_state = 0;
                    end else begin
                        modelEnterError(1'b0);
                    end
                end else if (m_tmo == TIMEOUT - 1) begin
                    modelEnterError(1'b1);
                end else begin
                    m_tmo++;
                end
            end
            default: if (c) begin m_state = 0; m_err = 1'b0; m_etmo = 1'b0; end
        endcase

        e.err  = m_err;
        e.etmo = m_etmo;
        e.cnt  = m_cnt;
        scoreboard.push_back(e);

        #2;
        got.lden  = buf_lden;
        got.stall = main_stall;
        @(posedge clk);
        #1;
        got.err  = lkstp_err;
        got.etmo = err_timeout;
        got.cnt  = mis_cnt;

        e = scoreboard.pop_front();
        checkOutput({tag, ".lden"},  32'(got.lden),  32'(e.lden));
        checkOutput({tag, ".stall"}, 32'(got.stall), 32'(e.stall));
        checkOutput({tag, ".err"},   32'(got.err),   32'(e.err));
        checkOutput({tag, ".etmo"},  32'(got.etmo),  32'(e.etmo));
        checkOutput({tag, ".cnt"},   32'(got.cnt),   32'(e.cnt));
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    // Asserts reset, checks every output is cleared, releases on a falling edge.
    task automatic doReset(input string tag);
        rst_n    = 1'b0;
        main_evt = 1'b0;
        main_sig = '0;
        red_evt  = 1'b0;
        red_sig  = '0;
        clr_err  = 1'b0;
        m_state  = 0;
        m_sig    = '0;
        m_tmo    = 0;
        m_err    = 1'b0;
        m_etmo   = 1'b0;
        m_cnt    = '0;
        #2;
        checkOutput({tag, ".lden"},  32'(buf_lden),    32'd0);
        checkOutput({tag, ".stall"}, 32'(main_stall),  32'd0);
        checkOutput({tag, ".err"},   32'(lkstp_err),   32'd0);
        checkOutput({tag, ".etmo"},  32'(err_timeout), 32'd0);
        checkOutput({tag, ".cnt"},   32'(mis_cnt),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic            rm;
        logic            rr;
        logic [SIGW-1:0] rs;

        $display("[TB] lsu_lockstep_ctrl bench start");
        doReset("rst0");

        // Single event, consumed three cycles later with the same signature.
        applyStimulus("single_cap", 1'b1, 32'hA5A5_0001, 1'b0, '0, 1'b0);
        idle("single_wait", 2);
        applyStimulus("single_use", 1'b0, '0, 1'b1, 32'hA5A5_0001, 1'b0);
        idle("single_after", 1);

        // Back-to-back refill in FULL, then drain.
        applyStimulus("b2b_cap", 1'b1, 32'h1, 1'b0, '0, 1'b0);
        applyStimulus("b2b_refill", 1'b1, 32'h2, 1'b1, 32'h1, 1'b0);
        applyStimulus("b2b_drain", 1'b0, '0, 1'b1, 32'h2, 1'b0);
        idle("b2b_after", 1);

        // Signature mismatch, error held, ignored main_evt, then cleared.
        applyStimulus("mis_cap", 1'b1, 32'h10, 1'b0, '0, 1'b0);
        applyStimulus("mis_use", 1'b0, '0, 1'b1, 32'h11, 1'b0);
        applyStimulus("mis_hold", 1'b1, 32'h55, 1'b0, '0, 1'b0);
        applyStimulus("mis_clr", 1'b0, '0, 1'b0, '0, 1'b1);
        applyStimulus("mis_after", 1'b0, '0, 1'b0, '0, 1'b1);

        // Stall protocol: main_evt while stalled must not overwrite the slot.
        applyStimulus("stall_cap", 1'b1, 32'h30, 1'b0, '0, 1'b0);
        applyStimulus("stall_viol", 1'b1, 32'h99, 1'b0, '0, 1'b0);
        applyStimulus("stall_use", 1'b0, '0, 1'b1, 32'h30, 1'b0);

        // Consumption in the last allowed FULL cycle: no error.
        applyStimulus("tmo_ok_cap", 1'b1, 32'h40, 1'b0, '0, 1'b0);
        idle("tmo_ok_wait", TIMEOUT - 1);
        applyStimulus("tmo_ok_use", 1'b0, '0, 1'b1, 32'h40, 1'b0);

        // TIMEOUT cycles without consumption: timeout error.
        applyStimulus("tmo_cap", 1'b1, 32'h41, 1'b0, '0, 1'b0);
        idle("tmo_wait", TIMEOUT);
        applyStimulus("tmo_late_use", 1'b0, '0, 1'b1, 32'h41, 1'b0);
        applyStimulus("tmo_clr", 1'b0, '0, 1'b0, '0, 1'b1);

        // Random traffic with occasional corrupted replays and clears.
        for (int i = 0; i < 200; i++) begin
            rm = ($urandom_range(0, 1) == 0);
            rr = ($urandom_range(0, 2) != 0);
            rs = ($urandom_range(0, 9) == 0) ? (m_sig ^ 32'h1) : m_sig;
            applyStimulus("rand", rm, $urandom, rr, rs, $urandom_range(0, 3) == 0);
        end
        if (m_state == 2) applyStimulus("rand_clr", 1'b0, '0, 1'b0, '0, 1'b1);
        if (m_state == 1) applyStimulus("rand_drain", 1'b0, '0, 1'b1, m_sig, 1'b0);

        // Many errors so the optional counter reaches saturation.
        for (int i = 0; i < 300; i++) begin
            applyStimulus("cnt_cap", 1'b1, 32'(i), 1'b0, '0, 1'b0);
            applyStimulus("cnt_bad", 1'b0, '0, 1'b1, ~32'(i), 1'b0);
            applyStimulus("cnt_clr", 1'b0, '0, 1'b0, '0, 1'b1);
        end

        // Reset while FULL drops the held event and clears everything.
        applyStimulus("rstmid_cap", 1'b1, 32'h77, 1'b0, '0, 1'b0);
        doReset("rstmid");
        idle("rstmid_after", 2);

        if (scoreboard.size() != 0) begin
            checkOutput("sb_empty", 32'(scoreboard.size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
